srl_fifo_ctrl: RTL and testbench

- Control and sequencing logic for the HLS-style SRL storage primitive: a DEPTH-entry shift register with write-enable, read address and combinational data-out.
- Turns that primitive into a first-word-fall-through FIFO with an output register, using the standard if_* full_n/empty_n handshake.
- Used for the start-token and stream FIFOs between dataflow processes, such as the PE start channels. The storage instance sits outside this block and is driven through the srl_* ports.

---
 rtl/srl_fifo_ctrl_if.sv | 27 ++
 rtl/srl_fifo_ctrl.sv | 48 ++++
 tb/tb_srl_fifo_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/srl_fifo_ctrl_if.sv
// srl_fifo_ctrl_if: bundles the FIFO write/read handshake, occupancy and the external SRL storage port.
interface srl_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic                  srl_we;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_din;
    logic [DATA_WIDTH-1:0] srl_dout;
    logic [ADDR_WIDTH:0]   usedw;
    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read, srl_dout,
        output if_full_n, if_dout, if_empty_n, srl_we, srl_addr, srl_din, usedw
    );
    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read, srl_dout,
        input  if_full_n, if_dout, if_empty_n, srl_we, srl_addr, srl_din, usedw
    );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: wraps an external shift-register store into a first-word-fall-through FIFO
// with an output register; total capacity is DEPTH+1.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input logic           clk,
    input logic           reset_n,
    srl_fifo_ctrl_if.slave bus
);
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  full_n_q, full_n_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  push, pop_out, load;
    always_comb begin
        push        = bus.if_write & bus.if_write_ce & full_n_q;
        pop_out     = bus.if_read & bus.if_read_ce & out_valid_q;
        load        = (count_q != '0) & (~out_valid_q | pop_out);
        // push and load together leave the head address unchanged: read before shift, new head lands there
        count_d     = (push & ~load) ? count_q + (ADDR_WIDTH+1)'(1) :
                      (load & ~push) ? count_q - (ADDR_WIDTH+1)'(1) : count_q;
        out_valid_d = load ? 1'b1 : pop_out ? 1'b0 : out_valid_q;
        dout_d      = load ? bus.srl_dout : dout_q;
        full_n_d    = count_d != (ADDR_WIDTH+1)'(DEPTH);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            full_n_q    <= 1'b0;
            dout_q      <= '0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            full_n_q    <= full_n_d;
            dout_q      <= dout_d;
        end
    end
    assign bus.srl_we     = push;
    assign bus.srl_din    = bus.if_din;
    assign bus.srl_addr   = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - (ADDR_WIDTH+1)'(1));
    assign bus.if_full_n  = full_n_q;
    assign bus.if_empty_n = out_valid_q;
    assign bus.if_dout    = dout_q;
    assign bus.usedw      = count_q;
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb_srl_fifo_ctrl: directed and randomized checks of the SRL FIFO controller against a queue model.
module tb_srl_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 1;
    localparam int D  = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    srl_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    // external shift-register storage the controller drives
    logic [DW-1:0] srl_mem [D];
    always @(posedge clk) if (bus.srl_we) begin
        for (int i = D - 1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
        srl_mem[0] <= bus.srl_din;
    end
    assign bus.srl_dout = srl_mem[bus.srl_addr];
    // reference: words waiting in the SRL, plus a visible head slot
    logic [DW-1:0] mq [$];
    bit            ov_m, full_m;
    logic [DW-1:0] dout_m;
    int vectors = 0, miscompares = 0;
    task automatic model_reset();
        mq.delete(); ov_m = 0; full_m = 0; dout_m = '0;
    endtask
    task automatic step(input bit wr, input logic [DW-1:0] din, input bit wce, input bit rd, input bit rce);
        bit push, pop, load;
        bus.if_write = wr; bus.if_din = din; bus.if_write_ce = wce;
        bus.if_read = rd; bus.if_read_ce = rce;
        #1;
        push = wr && wce && full_m;
        pop  = rd && rce && ov_m;
        load = mq.size() != 0 && (!ov_m || pop);
        vectors++;
        if (bus.srl_we !== push) begin
            miscompares++; $display("FAIL srl_we got %b want %b", bus.srl_we, push);
        end
        @(posedge clk);
        if (load) begin dout_m = mq.pop_front(); ov_m = 1; end
        else if (pop) ov_m = 0;
        if (push) mq.push_back(din);
        full_m = mq.size() != D;
        #1;
    endtask
    task automatic test_reset();
        reset_n = 1'b0;
        bus.if_write = 1; bus.if_write_ce = 1; bus.if_din = 8'h5A; bus.if_read = 0; bus.if_read_ce = 1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if ({bus.if_full_n, bus.if_empty_n, bus.usedw, bus.if_dout, bus.srl_we, bus.srl_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset full_n=%b empty_n=%b usedw=%0d dout=%h we=%b addr=%0d want all zero",
                     bus.if_full_n, bus.if_empty_n, bus.usedw, bus.if_dout, bus.srl_we, bus.srl_addr);
        end
        bus.if_write = 0;
        reset_n = 1'b1;
        #1;
        vectors++;
        if (bus.if_full_n !== 1'b0) begin miscompares++; $display("FAIL release_full_n got %b want 0", bus.if_full_n); end
        step(0, 0, 1, 0, 1);
        vectors++;
        if (bus.if_full_n !== 1'b1) begin miscompares++; $display("FAIL first_edge_full_n got %b want 1", bus.if_full_n); end
    endtask
    task automatic test_single();
        step(1, 8'hA5, 1, 0, 1);
        vectors++;
        if ({bus.if_empty_n, bus.usedw} !== {1'b0, 2'd1}) begin
            miscompares++; $display("FAIL single_t0 empty_n=%b usedw=%0d want 0,1", bus.if_empty_n, bus.usedw);
        end
        step(0, 0, 1, 0, 1);
        vectors++;
        if ({bus.if_empty_n, bus.if_dout, bus.usedw} !== {1'b1, 8'hA5, 2'd0}) begin
            miscompares++; $display("FAIL single_t1 empty_n=%b dout=%h usedw=%0d want 1,a5,0", bus.if_empty_n, bus.if_dout, bus.usedw);
        end
        step(0, 0, 1, 1, 1);
        vectors++;
        if ({bus.if_empty_n, bus.if_dout} !== {1'b0, 8'hA5}) begin
            miscompares++; $display("FAIL single_read empty_n=%b dout=%h want 0,a5 (stale)", bus.if_empty_n, bus.if_dout);
        end
    endtask
    task automatic test_fill();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                vectors++;
                if ({bus.if_full_n, bus.usedw} !== {1'b0, 2'd2}) begin
                    miscompares++; $display("FAIL fill_full full_n=%b usedw=%0d want 0,2", bus.if_full_n, bus.usedw);
                end
            end
            step(1, DW'(k), 1, 0, 1);
            vectors++;
            if ({bus.if_full_n, bus.if_empty_n, bus.usedw, bus.if_dout} !== {full_m, ov_m, 2'(mq.size()), dout_m}) begin
                miscompares++; $display("FAIL fill_%0d got %b/%b/%0d/%h want %b/%b/%0d/%h", k, bus.if_full_n,
                    bus.if_empty_n, bus.usedw, bus.if_dout, full_m, ov_m, mq.size(), dout_m);
            end
        end
        for (int k = 1; k <= 3; k++) begin
            vectors++;
            if ({bus.if_empty_n, bus.if_dout} !== {1'b1, DW'(k)}) begin
                miscompares++; $display("FAIL drain_%0d empty_n=%b dout=%h want 1,%h", k, bus.if_empty_n, bus.if_dout, k);
            end
            step(0, 0, 1, 1, 1);
        end
        vectors++;
        if ({bus.if_empty_n, bus.if_full_n, bus.usedw} !== {1'b0, 1'b1, 2'd0}) begin
            miscompares++; $display("FAIL drain_end empty_n=%b full_n=%b usedw=%0d want 0,1,0", bus.if_empty_n, bus.if_full_n, bus.usedw);
        end
    endtask
    task automatic test_stream();
        logic [DW-1:0] got [$];
        bit bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.if_empty_n === 1'b1) got.push_back(bus.if_dout);
            step(k < 16, DW'(8'h10 + k), 1, 1, 1);
            if (bus.usedw > 1 || bus.if_full_n !== 1'b1) bad = 1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL stream_level usedw exceeded 1 or full_n dropped"); end
        vectors++;
        if (got.size() != 16) begin miscompares++; $display("FAIL stream_count got %0d want 16", got.size()); end
        for (int k = 0; k < got.size() && k < 16; k++) begin
            vectors++;
            if (got[k] !== DW'(8'h10 + k)) begin
                miscompares++; $display("FAIL stream_order[%0d] got %h want %h", k, got[k], 8'h10 + k);
            end
        end
    endtask
    task automatic test_ce();
        step(1, 8'h33, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 1, 0);
            vectors++;
            if ({bus.if_empty_n, bus.if_dout} !== {1'b1, 8'h33}) begin
                miscompares++; $display("FAIL read_ce_%0d empty_n=%b dout=%h want 1,33", k, bus.if_empty_n, bus.if_dout);
            end
        end
        step(1, 8'h44, 0, 0, 1);
        vectors++;
        if ({bus.usedw, bus.if_dout} !== {2'd0, 8'h33}) begin
            miscompares++; $display("FAIL write_ce usedw=%0d dout=%h want 0,33", bus.usedw, bus.if_dout);
        end
        step(0, 0, 1, 1, 1);
        vectors++;
        if (bus.if_empty_n !== 1'b0) begin miscompares++; $display("FAIL ce_drain empty_n=%b want 0", bus.if_empty_n); end
    endtask
    task automatic test_random();
        logic [DW-1:0] exp [$];
        for (int k = 0; k < 400; k++) begin
            bit wr = 1'($urandom_range(0, 1)), wce = $urandom_range(0, 3) != 0;
            bit rd = 1'($urandom_range(0, 1)), rce = $urandom_range(0, 3) != 0;
            logic [DW-1:0] din = DW'($urandom);
            if (rd && rce && bus.if_empty_n === 1'b1) begin
                vectors++;
                if (exp.size() == 0 || bus.if_dout !== exp[0]) begin
                    miscompares++; $display("FAIL rand_order[%0d] got %h want %h", k, bus.if_dout, exp.size() ? exp[0] : 'x);
                end
                if (exp.size()) void'(exp.pop_front());
            end
            if (wr && wce && full_m) exp.push_back(din);
            step(wr, din, wce, rd, rce);
            vectors++;
            if ({bus.if_full_n, bus.if_empty_n, bus.usedw, bus.if_dout} !== {full_m, ov_m, 2'(mq.size()), dout_m}) begin
                miscompares++; $display("FAIL rand_%0d got %b/%b/%0d/%h want %b/%b/%0d/%h", k, bus.if_full_n,
                    bus.if_empty_n, bus.usedw, bus.if_dout, full_m, ov_m, mq.size(), dout_m);
            end
        end
        while (ov_m || mq.size() != 0) step(0, 0, 1, 1, 1);
    endtask
    task automatic test_midreset();
        step(1, 8'hC1, 1, 0, 1);
        step(1, 8'hC2, 1, 0, 1);
        step(1, 8'hC3, 1, 0, 1);
        bus.if_write = 0; bus.if_read = 0;
        vectors++;
        if ({bus.if_full_n, bus.usedw} !== {1'b0, 2'd2}) begin
            miscompares++; $display("FAIL mid_full full_n=%b usedw=%0d want 0,2", bus.if_full_n, bus.usedw);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({bus.if_full_n, bus.if_empty_n, bus.usedw, bus.if_dout, bus.srl_addr} !== '0) begin
            miscompares++; $display("FAIL mid_reset full_n=%b empty_n=%b usedw=%0d dout=%h addr=%0d want all zero",
                bus.if_full_n, bus.if_empty_n, bus.usedw, bus.if_dout, bus.srl_addr);
        end
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        full_m = 1;
        step(1, 8'h77, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        vectors++;
        if ({bus.if_empty_n, bus.if_dout, bus.usedw} !== {1'b1, 8'h77, 2'd0}) begin
            miscompares++; $display("FAIL mid_new empty_n=%b dout=%h usedw=%0d want 1,77,0", bus.if_empty_n, bus.if_dout, bus.usedw);
        end
        step(0, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 1, 1);
            vectors++;
            if ({bus.if_empty_n, bus.usedw} !== {1'b0, 2'd0}) begin
                miscompares++; $display("FAIL mid_only_%0d empty_n=%b usedw=%0d want 0,0", k, bus.if_empty_n, bus.usedw);
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_ce();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
